// File: rtl/timer_pkg.sv
// Shared state encoding for the timer arbiter FSM.
// Optional abort behaviour is selected by TIMER_ARBITER_ABORT_EN in timer_arbiter.
package timer_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_LOAD = LOAD,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requesting channel at or after pointer,
// wrapping modulo requesters.
module rr_priority_picker #(
    parameter int requesters = 4,
    parameter int ptr_width  = $clog2(requesters)
) (
    input  logic [requesters-1:0] request,
    input  logic [ptr_width-1:0]  pointer,
    output logic [requesters-1:0] pick,
    output logic                  valid
);

    logic [ptr_width-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = requesters - 1; k >= 0; k--) begin
            idx = ptr_width'((int'(pointer) + k) % requesters);
            if (request[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one shared interval timer to a single requester at a time.
// Define TIMER_ARBITER_ABORT_EN to let a granted channel abandon its interval by dropping request.
module timer_arbiter
    import timer_pkg::*;
#(
    parameter int requesters = 4,
    parameter int bitwidth   = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [requesters-1:0]          request,
    input  logic [requesters*bitwidth-1:0] duration,
    output logic [requesters-1:0]          grant,
    output logic                           busy,
    output logic [bitwidth-1:0]            value,
    output logic [requesters-1:0]          done
);

    localparam int PW = $clog2(requesters);

    state_t                  state_reg;
    logic [PW-1:0]           pointer_reg;
    logic [PW-1:0]           sel_reg;
    logic [requesters-1:0]   grant_reg;
    logic                    busy_reg;
    logic [requesters-1:0]   done_reg;
    logic [bitwidth-1:0]     value_reg;
    logic [bitwidth-1:0]     active_duration_reg;

    logic [requesters-1:0]   pick;
    logic                    pick_valid;
    logic [PW-1:0]           pick_idx;
    logic [PW-1:0]           next_ptr;
    logic [bitwidth-1:0]     dur_arr [requesters];

    genvar gi;
    generate
        for (gi = 0; gi < requesters; gi++) begin : g_dur
            assign dur_arr[gi] = duration[gi*bitwidth +: bitwidth];
        end
    endgenerate

    rr_priority_picker #(
        .requesters (requesters),
        .ptr_width  (PW)
    ) u_picker (
        .request (request),
        .pointer (pointer_reg),
        .pick    (pick),
        .valid   (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < requesters; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

    assign next_ptr = (sel_reg == PW'(requesters - 1)) ? '0 : sel_reg + PW'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg           <= ST_IDLE;
            pointer_reg         <= '0;
            sel_reg             <= '0;
            grant_reg           <= '0;
            busy_reg            <= 1'b0;
            done_reg            <= '0;
            value_reg           <= '0;
            active_duration_reg <= '0;
        end else begin
            done_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_reg           <= ST_LOAD;
                        grant_reg           <= pick;
                        busy_reg            <= 1'b1;
                        sel_reg             <= pick_idx;
                        active_duration_reg <= dur_arr[pick_idx];
                        value_reg           <= '0;
                    end
                end
                ST_LOAD: begin
`ifdef TIMER_ARBITER_ABORT_EN
                    if (!request[sel_reg]) begin
                        state_reg   <= ST_IDLE;
                        grant_reg   <= '0;
                        busy_reg    <= 1'b0;
                        pointer_reg <= next_ptr;
                    end else
`endif
                    if (active_duration_reg == '0) begin
                        state_reg   <= ST_DONE;
                        done_reg    <= grant_reg;
                        pointer_reg <= next_ptr;
                    end else begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
`ifdef TIMER_ARBITER_ABORT_EN
                    if (!request[sel_reg]) begin
                        state_reg   <= ST_IDLE;
                        grant_reg   <= '0;
                        busy_reg    <= 1'b0;
                        pointer_reg <= next_ptr;
                    end else
`endif
                    begin
                        // value lands on active_duration exactly as DONE is entered
                        value_reg <= value_reg + bitwidth'(1);
                        if (value_reg == active_duration_reg - bitwidth'(1)) begin
                            state_reg   <= ST_DONE;
                            done_reg    <= grant_reg;
                            pointer_reg <= next_ptr;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    grant_reg <= '0;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign grant = grant_reg;
    assign busy  = busy_reg;
    assign value = value_reg;
    assign done  = done_reg;

endmodule
